mont_enc: RTL
=============

MONT_ENC -- requirements
Module: mont_enc

Interface
REQ-001 Parameter n, default 65'd21536215303153667899: odd modulus; 2^64 < n < 2^65.
REQ-002 Parameter W, default 65: operand width; R = 2^W.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand a is presented.
REQ-006 in_ready  output  1  block can accept an operand.
REQ-007 a  input  W  normal-domain operand.
REQ-008 out_valid  output  1  result x is valid.
REQ-009 out_ready  input  1  consumer accepts x.
REQ-010 x  output  W  Montgomery-domain result, x = a*R mod n.

Function
REQ-011 The block SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 In IDLE: in_ready=1 and out_valid=0; in RUN and DONE: in_ready=0.
REQ-013 Accept occurs on an edge with in_valid=1 and in_ready=1.
REQ-014 On accept: acc (W+1 bits) <= (a >= n) ? a-n : a; counter <= 0; state <= RUN.
REQ-015 a is sampled only at accept; later changes to a SHALL NOT affect the result.
REQ-016 Each RUN edge: acc <= 2*acc, minus n when 2*acc >= n (compared at W+1 bits); counter increments.
REQ-017 acc SHALL remain < n after every step, with no overflow of the W+1-bit datapath.
REQ-018 After the 65th RUN edge (counter reaches W-1 and then steps): state <= DONE and out_valid <= 1.
REQ-019 Latency: out_valid rises exactly W=65 clock edges after the accept edge.
REQ-020 x SHALL equal acc[W-1:0] and be held stable while out_valid=1.
REQ-021 In DONE, out_valid SHALL hold until out_ready=1; on that edge: out_valid <= 0 and state <= IDLE.
REQ-022 in_ready SHALL return to 1 on the cycle after the output handshake.
REQ-023 An input and an output handshake SHALL never occur on the same edge.
REQ-024 in_valid during RUN or DONE SHALL be ignored; the request is not queued.
REQ-025 out_ready while not in DONE SHALL have no effect.
REQ-026 No multiplier SHALL be used; the datapath is an adder/subtractor plus comparator only.

Reset
REQ-027 rst_n=0 SHALL immediately force: state=IDLE, acc=0, counter=0, out_valid=0, x=0, in_ready=1.
REQ-028 Reset during RUN or DONE SHALL abort the operation and discard the result, with no spurious out_valid.
REQ-029 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-030 a=0, out_ready=1 -> out_valid exactly 65 edges after accept, x=0.
REQ-031 a=1 -> x=15357272844265435333 (R mod n); a=15357272844265435333 -> x=15661607970342841481 (R^2 mod n).
REQ-032 a=n-1=21536215303153667898 -> x=6178942458888232566; a=n (out of range) -> x=0.
REQ-033 Back-pressure: out_ready=0 for 10 cycles after out_valid, in_valid held at 1 with changing a -> x and out_valid stable, in_ready=0 throughout; next accept happens one cycle after the output handshake.
REQ-034 Reset pulse at RUN cycle 30 -> outputs take their reset values immediately and no out_valid follows; a new operand a=1 then yields 15357272844265435333.
REQ-035 Random back-to-back operands a<n checked against the reference model a*2^65 mod n -> all match at 65-cycle latency.

Source files
------------

// File: rtl/mont_enc.sv
// Montgomery-domain encoder: computes x = a * 2^W mod n by W rounds of
// modular doubling on a W+1-bit accumulator (adder/subtractor + comparator only).
module mont_enc #(
  parameter int unsigned  W = 65,
  parameter logic [W-1:0] n = 65'd21536215303153667899
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] x
);

  localparam int unsigned CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [W:0]    acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [W:0] n_ext;
  logic [W:0] a_ext;
  logic [W:0] dbl;

  assign n_ext = {1'b0, n};
  assign a_ext = {1'b0, a};
  // acc stays below n < 2^W, so the doubled value always fits in W+1 bits
  assign dbl   = acc_q << 1;

  // State, accumulator and round counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, datapath step and handshake outputs
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d   = (a_ext >= n_ext) ? (a_ext - n_ext) : a_ext;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = (dbl >= n_ext) ? (dbl - n_ext) : dbl;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign x = acc_q[W-1:0];

endmodule
